// File: rtl/mul_add_pipe.sv
// Pipelined unsigned multiply-add / accumulate unit.
// Product and sideband travel STAGES deep, then a single result stage updates F/acc/ovf.
module mul_add_pipe #(
    parameter int W      = 8,
    parameter int STAGES = 2,
    parameter int G      = 4,
    localparam int OW    = 2*W + G
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic          in_valid,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic [W-1:0]  c,
    input  logic          mode,
    input  logic          clr,
    output logic [OW-1:0] F,
    output logic          out_valid,
    output logic          ovf
);

    logic [STAGES:1][2*W-1:0] r_p;
    logic [STAGES:1][W-1:0]   r_c;
    logic [STAGES:1]          r_mode;
    logic [STAGES:1]          r_clr;
    logic [STAGES:1]          r_vld_pipe;
    logic [OW-1:0]            r_acc;

    logic [2*W-1:0]           w_prod;
    logic [OW-1:0]            w_pz;
    logic [OW-1:0]            w_cz;
    logic [OW:0]              w_sum;

    assign w_prod = (2*W)'(a) * (2*W)'(b);
    assign w_pz   = OW'(r_p[STAGES]);
    assign w_cz   = OW'(r_c[STAGES]);
    // One extra bit catches the carry out of the accumulator for ovf.
    assign w_sum  = {1'b0, r_acc} + {1'b0, w_pz};

    // Data pipeline needs no reset: only the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (ce) begin
            r_p[1]    <= w_prod;
            r_c[1]    <= c;
            r_mode[1] <= mode;
            r_clr[1]  <= clr;
            for (int s = 2; s <= STAGES; s++) begin
                r_p[s]    <= r_p[s-1];
                r_c[s]    <= r_c[s-1];
                r_mode[s] <= r_mode[s-1];
                r_clr[s]  <= r_clr[s-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_pipe <= '0;
        end else if (ce) begin
            r_vld_pipe[1] <= in_valid;
            for (int s = 2; s <= STAGES; s++)
                r_vld_pipe[s] <= r_vld_pipe[s-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            F         <= '0;
            r_acc     <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else if (ce) begin
            out_valid <= r_vld_pipe[STAGES];
            if (r_vld_pipe[STAGES]) begin
                if (!r_mode[STAGES]) begin
                    F <= w_pz + w_cz;
                end else if (r_clr[STAGES]) begin
                    r_acc <= w_pz;
                    ovf   <= 1'b0;
                    F     <= w_pz;
                end else begin
                    r_acc <= w_sum[OW-1:0];
                    ovf   <= ovf | w_sum[OW];
                    F     <= w_sum[OW-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_mul_add_pipe.sv
// Bench for mul_add_pipe: queue-based reference model checked every cycle, plus literal pins.
module tb_mul_add_pipe;
    localparam int W = 8, STAGES = 2, G = 4, OW = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ce = 1'b1;
    logic          in_valid = 1'b0;
    logic [W-1:0]  a = '0, b = '0, c = '0;
    logic          mode = 1'b0, clr = 1'b0;
    logic [OW-1:0] F;
    logic          out_valid, ovf;

    mul_add_pipe #(.W(W), .STAGES(STAGES), .G(G)) dut (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid),
        .a(a), .b(b), .c(c), .mode(mode), .clr(clr),
        .F(F), .out_valid(out_valid), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    endtask

    // Reference model: each accepted sample is due STAGES ce-edges after acceptance.
    typedef struct {int due; bit m; bit cl; int p; int cv;} smp_t;
    smp_t q[$];
    smp_t s;
    int   ce_cnt = 0, m_acc = 0, e_F = 0, p_in = 0;
    bit   m_ovf = 0, e_ov = 0, armed = 0;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_acc = 0; m_ovf = 0; e_F = 0; e_ov = 0; armed = 1;
        end else if (ce) begin
            ce_cnt++;
            e_ov = 0;
            if (q.size() > 0 && q[0].due == ce_cnt) begin
                s = q.pop_front();
                e_ov = 1;
                if (!s.m) e_F = s.p + s.cv;
                else if (s.cl) begin
                    m_acc = s.p; m_ovf = 0; e_F = m_acc;
                end else begin
                    m_acc = m_acc + s.p;
                    if (m_acc >= (1 << OW)) begin
                        m_acc = m_acc - (1 << OW); m_ovf = 1;
                    end
                    e_F = m_acc;
                end
            end
            if (in_valid) begin
                p_in = int'(a) * int'(b);
                s.due = ce_cnt + STAGES; s.m = mode; s.cl = clr; s.p = p_in; s.cv = int'(c);
                q.push_back(s);
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("model_out_valid", 32'(out_valid), 32'(e_ov));
            chk("model_F", 32'(F), 32'(e_F));
            chk("model_ovf", 32'(ovf), 32'(m_ovf));
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        in_valid = 0; a = '0; b = '0; c = '0; mode = 0; clr = 0;
    endtask

    task automatic put(input bit m, input bit cl, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic [W-1:0] cv);
        in_valid = 1; mode = m; clr = cl; a = av; b = bv; c = cv;
    endtask

    int seen = 0;
    task automatic acc_rec();
        if (out_valid) begin
            if (seen == 15) begin
                chk("acc16_F", 32'(F), 32'd1040400); chk("acc16_ovf", 32'(ovf), 32'd0);
            end else if (seen == 16) begin
                chk("acc17_F", 32'(F), 32'd56849); chk("acc17_ovf", 32'(ovf), 32'd1);
            end else if (seen == 17) begin
                chk("accclr_F", 32'(F), 32'd1); chk("accclr_ovf", 32'(ovf), 32'd0);
            end
            seen++;
        end
    endtask

    int cnt = 0;
    initial begin
        // reset with random inputs
        repeat (2) begin
            in_valid = 1'($urandom); a = W'($urandom); b = W'($urandom); c = W'($urandom);
            mode = 1'($urandom); clr = 1'($urandom); ce = 1'($urandom);
            step();
        end
        chk("rst_F", 32'(F), 0); chk("rst_ov", 32'(out_valid), 0); chk("rst_ovf", 32'(ovf), 0);
        rst = 0; ce = 1; idle();

        // max multiply-add
        put(0, 0, 255, 255, 255); step(); idle();
        step(); chk("max_early", 32'(out_valid), 0);
        step(); chk("max_F", 32'(F), 65280); chk("max_ov", 32'(out_valid), 1);
        step(); chk("max_once", 32'(out_valid), 0);

        // throughput
        put(0, 0, 2, 3, 4); step();
        put(0, 0, 5, 6, 7); step();
        put(0, 0, 10, 10, 0); step(); idle();
        chk("tp0_F", 32'(F), 10); chk("tp0_ov", 32'(out_valid), 1);
        step(); chk("tp1_F", 32'(F), 37); chk("tp1_ov", 32'(out_valid), 1);
        step(); chk("tp2_F", 32'(F), 100); chk("tp2_ov", 32'(out_valid), 1);
        step(); chk("tp_end_ov", 32'(out_valid), 0);

        // accumulate wrap, c ignored in mode 1
        for (int i = 0; i < 18; i++) begin
            if (i < 17) put(1, (i == 0), 255, 255, 8'd33);
            else        put(1, 1, 1, 1, 8'd9);
            step(); acc_rec();
        end
        idle();
        repeat (4) begin step(); acc_rec(); end
        chk("acc_count", 32'(seen), 18);

        // stall in flight
        put(0, 0, 3, 4, 5); step(); idle();
        ce = 0; step(); step(); chk("stall_ov0", 32'(out_valid), 0);
        ce = 1; step(); chk("stall_ov1", 32'(out_valid), 0);
        step(); chk("stall_F", 32'(F), 17); chk("stall_ov", 32'(out_valid), 1);
        ce = 0; step(); chk("stall_hold_ov", 32'(out_valid), 1); chk("stall_hold_F", 32'(F), 17);
        ce = 1; step(); chk("stall_after_ov", 32'(out_valid), 0);

        // mixed modes, clr ignored in mode 0
        put(1, 1, 7, 8, 0); step();
        put(0, 1, 9, 9, 200); step();
        put(1, 0, 10, 10, 50); step();
        chk("mix0_F", 32'(F), 56);
        put(0, 0, 1, 1, 1); step(); idle();
        chk("mix1_F", 32'(F), 281);
        step(); chk("mix2_F", 32'(F), 156);
        step(); chk("mix3_F", 32'(F), 2);

        // random traffic with stalls, checked by the model
        repeat (80) begin
            ce = ($urandom_range(3, 0) != 0);
            in_valid = 1'($urandom); a = W'($urandom); b = W'($urandom); c = W'($urandom);
            mode = 1'($urandom); clr = ($urandom_range(5, 0) == 0);
            step();
        end
        ce = 1; idle();
        repeat (5) step();

        // reset mid-flight
        rst = 1; step(); rst = 0;
        put(0, 0, 200, 200, 200); step(); idle();
        rst = 1; step(); rst = 0;
        repeat (6) begin step(); if (out_valid) cnt++; end
        chk("midrst_ov_count", 32'(cnt), 0); chk("midrst_F", 32'(F), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
